// File: rtl/ring_buffer_ctrl.sv
// ring_buffer_ctrl
// Control and sequencing for a single-clock circular buffer. Owns the write
// and read pointers (modulo-DEPTH wrapping counters) and an occupancy FSM
// (S_EMPTY / S_PART / S_FULL). Presents valid/ready handshakes to a producer
// and a consumer and drives enables/addresses to an external storage array.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous reset, active HIGH despite the name
//   flush        synchronous clear of pointers and occupancy (top priority)
//   wr_valid     producer offers a write
//   wr_ready     controller can accept a write (!full && !flush)
//   rd_ready     consumer takes the entry at rd_addr
//   rd_valid     an entry is available at rd_addr (!empty && !flush)
//   wr_en        write strobe to storage (accepted write this cycle)
//   wr_addr      storage write address (write pointer)
//   rd_en        read/pop strobe (accepted read this cycle)
//   rd_addr      storage read address (read pointer)
//   count        occupancy, 0..DEPTH
//   empty, full  occupancy state flags
//
// Optional feature, macro RING_BUFFER_CTRL_THRESH_EN:
//   parameters AF_LEVEL / AE_LEVEL, registered outputs almost_full
//   (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL).

module ring_buffer_ctrl #(
    parameter  int unsigned DEPTH    = 8,
`ifdef RING_BUFFER_CTRL_THRESH_EN
    parameter  int unsigned AF_LEVEL = DEPTH - 1,
    parameter  int unsigned AE_LEVEL = 1,
`endif
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic [CW-1:0] count,
    output logic          empty,
`ifdef RING_BUFFER_CTRL_THRESH_EN
    output logic          almost_full,
    output logic          almost_empty,
`endif
    output logic          full
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count_nxt;

    // Wrap explicitly at DEPTH-1 so non-power-of-two depths never reach DEPTH.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        empty     = 1'b0;
        full      = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        count_nxt = count;

        empty    = (state == S_EMPTY);
        full     = (state == S_FULL);
        // Ready/valid depend only on registered state and flush, never on
        // the opposite handshake input.
        wr_ready = !full && !flush;
        rd_valid = !empty && !flush;
        wr_en    = wr_valid && wr_ready;
        rd_en    = rd_ready && rd_valid;

        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        case (state)
            S_EMPTY: if (wr_en) state_nxt = S_PART;
            S_PART: begin
                if (wr_en && !rd_en && (count == CW'(DEPTH - 1)))
                    state_nxt = S_FULL;
                else if (rd_en && !wr_en && (count == CW'(1)))
                    state_nxt = S_EMPTY;
            end
            S_FULL:  if (rd_en) state_nxt = S_PART;
            default: state_nxt = S_EMPTY;
        endcase

        if (flush) begin
            state_nxt = S_EMPTY;
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
            count   <= '0;
        end else if (flush) begin
            wr_addr <= '0;
            rd_addr <= '0;
            count   <= '0;
        end else begin
            if (wr_en) wr_addr <= ptr_inc(wr_addr);
            if (rd_en) rd_addr <= ptr_inc(rd_addr);
            count <= count_nxt;
        end
    end

`ifdef RING_BUFFER_CTRL_THRESH_EN
    // Evaluated on the next occupancy so the flags change on the same edge
    // as count (flush already folds into count_nxt).
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (32'(count_nxt) >= AF_LEVEL);
            almost_empty <= (32'(count_nxt) <= AE_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Self-checking bench for ring_buffer_ctrl (DEPTH = 8). A table of stimulus
// phases with hand-derived end states drives the block; a reference model
// checks per-cycle handshakes and pushes expected post-edge state to a
// scoreboard queue that is popped after each edge. Reset cases are written
// out by hand.

module tb_ring_buffer_ctrl;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic       rd_ready;
    logic       rd_valid;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [3:0] count;
    logic       empty;
    logic       full;
`ifdef RING_BUFFER_CTRL_THRESH_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    ring_buffer_ctrl #(
        .DEPTH(DEPTH)
`ifdef RING_BUFFER_CTRL_THRESH_EN
        , .AF_LEVEL(6)
        , .AE_LEVEL(2)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .count(count),
        .empty(empty),
`ifdef RING_BUFFER_CTRL_THRESH_EN
        .almost_full(almost_full),
        .almost_empty(almost_empty),
`endif
        .full(full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int m_cnt = 0;
    int m_wa  = 0;
    int m_ra  = 0;

    typedef struct {
        int cnt;
        int wa;
        int ra;
    } exp_t;
    exp_t sb[$];

    // One clock cycle: drive at negedge, check handshakes, push expected
    // post-edge state, then pop and compare after the posedge.
    task automatic step(input logic f, input logic wv, input logic rr);
        bit   e_wrdy, e_rvld, e_we, e_re;
        exp_t e;
        @(negedge clk);
        flush = f; wr_valid = wv; rd_ready = rr;
        #1;
        e_wrdy = (m_cnt != DEPTH) && !f;
        e_rvld = (m_cnt != 0) && !f;
        e_we   = wv && e_wrdy;
        e_re   = rr && e_rvld;
        chk("wr_ready", 32'(wr_ready), 32'(e_wrdy));
        chk("rd_valid", 32'(rd_valid), 32'(e_rvld));
        chk("wr_en",    32'(wr_en),    32'(e_we));
        chk("rd_en",    32'(rd_en),    32'(e_re));
        if (f) begin
            m_cnt = 0; m_wa = 0; m_ra = 0;
        end else begin
            m_cnt = m_cnt + int'(e_we) - int'(e_re);
            if (e_we) m_wa = (m_wa + 1) % DEPTH;
            if (e_re) m_ra = (m_ra + 1) % DEPTH;
        end
        e.cnt = m_cnt; e.wa = m_wa; e.ra = m_ra;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("count",   32'(count),   32'(e.cnt));
            chk("wr_addr", 32'(wr_addr), 32'(e.wa));
            chk("rd_addr", 32'(rd_addr), 32'(e.ra));
            chk("empty",   32'(empty),   32'(e.cnt == 0));
            chk("full",    32'(full),    32'(e.cnt == DEPTH));
`ifdef RING_BUFFER_CTRL_THRESH_EN
            chk("almost_full",  32'(almost_full),  32'(e.cnt >= 6));
            chk("almost_empty", 32'(almost_empty), 32'(e.cnt <= 2));
`endif
        end
    endtask

    typedef struct {
        string name;
        logic  f;
        logic  wv;
        logic  rr;
        int    reps;
        int    exp_cnt;
        int    exp_wa;
        int    exp_ra;
    } vec_t;

    vec_t vecs[12];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Phases applied in order from reset; end states derived by hand.
        vecs[0]  = '{"fill8",        0, 1, 0,  8, 8, 0, 0};
        vecs[1]  = '{"write_full",   0, 1, 0,  1, 8, 0, 0};
        vecs[2]  = '{"drain8",       0, 0, 1,  8, 0, 0, 0};
        vecs[3]  = '{"read_empty",   0, 0, 1,  1, 0, 0, 0};
        vecs[4]  = '{"fill3",        0, 1, 0,  3, 3, 3, 0};
        vecs[5]  = '{"simul20",      0, 1, 1, 20, 3, 7, 4};
        vecs[6]  = '{"drain3",       0, 0, 1,  3, 0, 7, 7};
        vecs[7]  = '{"both_at_0",    0, 1, 1,  1, 1, 0, 7};
        vecs[8]  = '{"fill7",        0, 1, 0,  7, 8, 7, 7};
        vecs[9]  = '{"both_at_8",    0, 1, 1,  1, 7, 7, 0};
        vecs[10] = '{"read1",        0, 0, 1,  1, 6, 7, 1};
        vecs[11] = '{"flush_at_6",   1, 1, 1,  1, 0, 0, 0};

        flush = 0; wr_valid = 0; rd_ready = 0;
        rst_n = 1'b1;
        // Reset held over several edges
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_count",    32'(count),    32'd0);
            chk("rst_empty",    32'(empty),    32'd1);
            chk("rst_full",     32'(full),     32'd0);
            chk("rst_wr_ready", 32'(wr_ready), 32'd1);
            chk("rst_rd_valid", 32'(rd_valid), 32'd0);
            chk("rst_rd_en",    32'(rd_en),    32'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;

        for (int v = 0; v < 12; v++) begin
            for (int r = 0; r < vecs[v].reps; r++)
                step(vecs[v].f, vecs[v].wv, vecs[v].rr);
            chk({vecs[v].name, "_count"}, 32'(count),   32'(vecs[v].exp_cnt));
            chk({vecs[v].name, "_wa"},    32'(wr_addr), 32'(vecs[v].exp_wa));
            chk({vecs[v].name, "_ra"},    32'(rd_addr), 32'(vecs[v].exp_ra));
        end
        step(0, 0, 0);

        // Thresholds: write 6 then read 4 (flags checked each cycle)
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        chk("thresh_seq_count", 32'(count), 32'd2);
        step(1, 0, 0);

        // Asynchronous reset pulse between edges at count = 5
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        chk("pre_async_count", 32'(count), 32'd5);
        #2 rst_n = 1'b1;
        #1;
        chk("async_count",   32'(count),   32'd0);
        chk("async_empty",   32'(empty),   32'd1);
        chk("async_wr_addr", 32'(wr_addr), 32'd0);
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b0;
        m_cnt = 0; m_wa = 0; m_ra = 0;
        step(0, 1, 0);
        step(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_buffer_ctrl.md
# ring_buffer_ctrl

Control and sequencing block for a single-clock circular buffer. It owns a write pointer and a read pointer, each a modulo-DEPTH wrapping counter, and tracks occupancy with a three-state FSM. It presents a valid/ready handshake on both sides and drives write/read enables and addresses to an external storage array. It sits between a producer, a consumer, and the buffer RAM/register file, and is the only block that advances the pointers.

## Interface
- DEPTH, 8, number of buffer entries; any integer ≥ 2, not necessarily a power of two.
- AW (localparam), $clog2(DEPTH), address width.
- CW (localparam), $clog2(DEPTH+1), occupancy width.
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-high reset (asserted = 1); clears all state immediately.
- flush  input  1  synchronous clear of pointers and occupancy.
- wr_valid  input  1  producer offers a write.
- wr_ready  output  1  controller can accept a write.
- rd_ready  input  1  consumer takes the entry at rd_addr.
- rd_valid  output  1  an entry is available at rd_addr.
- wr_en  output  1  write strobe to storage (= accepted write this cycle).
- wr_addr  output  AW  storage write address (= write pointer).
- rd_en  output  1  read/pop strobe (= accepted read this cycle).
- rd_addr  output  AW  storage read address (= read pointer).
- count  output  CW  current occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

## Operation
- FSM states: S_EMPTY, S_PART, S_FULL. Reset and flush enter S_EMPTY.
- Outputs decoded from state: empty = (S_EMPTY), full = (S_FULL), wr_ready = !full && !flush, rd_valid = !empty && !flush.
- Write accept: wr_en = wr_valid && wr_ready. Read accept: rd_en = rd_ready && rd_valid. Both are combinational from inputs and registered state.
- Pointer advance: on accept, the pointer becomes 0 if it equals DEPTH-1, else pointer+1. No other value is legal; pointers never reach DEPTH.
- Occupancy: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Transitions:
  - S_EMPTY -> S_PART on write. A read is impossible here because rd_valid is 0.
  - S_PART -> S_FULL on write-only when count == DEPTH-1.
  - S_PART -> S_EMPTY on read-only when count == 1.
  - S_PART stays in S_PART on both or neither.
  - S_FULL -> S_PART on read. A write is impossible here because wr_ready is 0, and there is no write-through when full.
- Simultaneous read and write in S_PART: both pointers advance; count and state are unchanged.
- flush: highest synchronous priority. wr_en and rd_en are forced 0 that cycle. Next edge: pointers = 0, count = 0, S_EMPTY.
- Reset mid-operation: all state clears asynchronously. Any in-flight accept is discarded.

## Timing
- Reset values: wr_addr = 0, rd_addr = 0, count = 0, empty = 1, full = 0, wr_ready = 1 (if flush = 0), rd_valid = 0, wr_en = 0, rd_en = 0.
- Handshake: a transfer occurs in the cycle valid && ready are high at posedge. State reflects it one cycle later.
- Write-to-read latency: a write accepted at edge N makes rd_valid = 1 after edge N (usable in cycle N+1). Storage must return data for rd_addr combinationally or with the consumer's own latency.
- Read frees space in the same edge. wr_ready rises in the cycle after the read edge from S_FULL.
- No combinational path from wr_valid to wr_ready, or from rd_ready to rd_valid.

## Configuration
- RING_BUFFER_CTRL_THRESH_EN defined:
  - Adds parameters AF_LEVEL (default DEPTH-1) and AE_LEVEL (default 1).
  - Adds outputs almost_full = (count ≥ AF_LEVEL) and almost_empty = (count ≤ AE_LEVEL).
  - Both outputs are registered, updated on the same edge as count, and take their reset values almost_full = 0, almost_empty = 1.
- Not defined: these ports and parameters do not exist. The core behaviour is identical.

## Test plan
- Reset, DEPTH = 8: hold rst_n = 1 over several edges -> count = 0, empty = 1, wr_ready = 1, rd_valid = 0. Pulse rst_n asynchronously between edges with count = 5 -> count reads 0 immediately.
- Fill: 8 back-to-back writes, no reads -> wr_addr steps 0..7 then wraps to 0. full = 1 after the 8th edge. A 9th wr_valid sees wr_en = 0 and count stays 8.
- Drain: 8 back-to-back reads from full -> rd_addr steps 0..7 then wraps to 0. empty = 1 after the 8th edge. Further rd_ready gives rd_en = 0.
- Simultaneous: at count = 3, assert wr_valid and rd_ready for 20 cycles -> count holds 3 and both pointers wrap twice, ending at (start + 20) mod 8. At count = 0 with both asserted -> write only, count = 1. At count = 8 with both asserted -> read only, count = 7.
- Flush: at count = 6, assert flush alongside wr_valid and rd_ready -> wr_en = 0, rd_en = 0. Next cycle: count = 0, pointers = 0, empty = 1.
- With RING_BUFFER_CTRL_THRESH_EN, AF_LEVEL = 6, AE_LEVEL = 2: write 6 entries -> almost_full = 1 after the 6th edge. Read 4 entries -> almost_empty = 1 when count = 2.
